// File: rtl/fetch_pkg.sv
// Shared types and helpers for the program-counter / instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned INSTR_W     = 32;

  // Fetch sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Branch controls presented alongside retire
  typedef struct packed {
    logic branch;
    logic uncond_branch;
    logic zero;
  } br_ctrl_t;

  // B always redirects; CBZ redirects only when the ALU result was zero
  function automatic logic branch_taken(input br_ctrl_t ctrl);
    return ctrl.uncond_branch | (ctrl.branch & ctrl.zero);
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Next-PC selection: sequential PC+4 or PC-relative branch target.
module next_pc_logic
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W = 64
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] bus_imm,
  input  br_ctrl_t        ctrl,
  output logic [PC_W-1:0] next_pc_c
);

  // Sums are modulo 2^PC_W; negative offsets arrive as two's complement
  always_comb begin
    next_pc_c = pc + PC_W'(INSTR_BYTES);
    if (branch_taken(ctrl)) begin
      next_pc_c = pc + bus_imm;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding instruction fetch stage.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned   PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned   CNT_W    = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] Instruction,
  output logic               instr_valid,
  input  logic               retire,
  input  logic               Branch,
  input  logic               Uncondbranch,
  input  logic               Zero,
  input  logic [PC_W-1:0]    BusImm,
  output logic [PC_W-1:0]    PC,
  output logic [CNT_W-1:0]   retired_count
);

  state_e             state_q;
  state_e             state_d;
  logic [PC_W-1:0]    pc_d;
  logic [INSTR_W-1:0] instr_d;
  logic               valid_d;
  logic               req_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic [PC_W-1:0]    next_pc_c;
  br_ctrl_t           ctrl_c;

  assign ctrl_c = '{branch: Branch, uncond_branch: Uncondbranch, zero: Zero};

  // The fetch address is the PC register itself
  assign imem_addr = PC;

  next_pc_logic #(
    .PC_W(PC_W)
  ) u_next_pc (
    .pc       (PC),
    .bus_imm  (BusImm),
    .ctrl     (ctrl_c),
    .next_pc_c(next_pc_c)
  );

  // Retired-instruction count saturates instead of wrapping
  always_comb begin
    cnt_inc_c = retired_count;
    if (retired_count != {CNT_W{1'b1}}) begin
      cnt_inc_c = retired_count + CNT_W'(1);
    end
  end

  // Next-state and next-register values; imem_ready/retire only matter in their own state
  always_comb begin
    state_d = state_q;
    pc_d    = PC;
    instr_d = Instruction;
    valid_d = instr_valid;
    cnt_d   = retired_count;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (retire) begin
          pc_d    = next_pc_c;
          valid_d = 1'b0;
          cnt_d   = cnt_inc_c;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_d = (state_d == FETCH);
  end

  // State and output registers; synchronous reset abandons any in-flight work
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q       <= IDLE;
      PC            <= RESET_PC;
      Instruction   <= '0;
      instr_valid   <= 1'b0;
      imem_req      <= 1'b0;
      retired_count <= '0;
    end else begin
      state_q       <= state_d;
      PC            <= pc_d;
      Instruction   <= instr_d;
      instr_valid   <= valid_d;
      imem_req      <= req_d;
      retired_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: stimulus pushes expectations, a monitor pops and compares.
module tb_fetch_pc_unit;

  localparam logic [63:0] RST_PC = 64'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        retire = 1'b0;
  logic        br = 1'b0;
  logic        ub = 1'b0;
  logic        zf = 1'b0;
  logic [63:0] bus_imm = '0;

  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [63:0] pc;
  logic [31:0] retired_count;

  logic        req2;
  logic [63:0] addr2;
  logic [31:0] instr2;
  logic        valid2;
  logic [63:0] pc2;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  fetch_pc_unit #(.PC_W(64), .RESET_PC(RST_PC), .CNT_W(32)) dut (
    .CLK(clk), .Reset(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .Instruction(instruction),
    .instr_valid(instr_valid), .retire(retire), .Branch(br), .Uncondbranch(ub),
    .Zero(zf), .BusImm(bus_imm), .PC(pc), .retired_count(retired_count)
  );

  fetch_pc_unit #(.PC_W(64), .RESET_PC(RST_PC), .CNT_W(2)) dut_sat (
    .CLK(clk), .Reset(rst), .imem_req(req2), .imem_addr(addr2),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .Instruction(instr2),
    .instr_valid(valid2), .retire(retire), .Branch(br), .Uncondbranch(ub),
    .Zero(zf), .BusImm(bus_imm), .PC(pc2), .retired_count(cnt2)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    int unsigned cnt;
  } exp_t;

  exp_t addr_q[$];
  exp_t instr_q[$];

  int checks = 0;
  int errors = 0;

  logic [63:0] pc_m;
  int unsigned cnt_m;

  function automatic int unsigned sat2(input int unsigned c);
    return (c > 3) ? 3 : c;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic summary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  // Monitor: compare on each new fetch request and each newly captured instruction
  initial begin
    logic        prev_req;
    logic        prev_valid;
    logic [63:0] held_addr;
    logic [31:0] held_instr;
    exp_t        e;
    prev_req = 1'b0;
    prev_valid = 1'b0;
    held_addr = '0;
    held_instr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0;
        prev_valid = 1'b0;
      end else begin
        chk("req_valid_exclusive", 64'(imem_req & instr_valid), 64'd0);
        if (imem_req && !prev_req) begin
          chk("fetch_expected", 64'(addr_q.size() != 0), 64'd1);
          if (addr_q.size() != 0) begin
            e = addr_q.pop_front();
            held_addr = e.pc;
            chk("fetch_addr", imem_addr, e.pc);
            chk("fetch_pc", pc, e.pc);
            chk("fetch_count", 64'(retired_count), 64'(e.cnt));
            chk("fetch_count_sat", 64'(cnt2), 64'(sat2(e.cnt)));
          end
        end else if (imem_req) begin
          chk("fetch_addr_stable", imem_addr, held_addr);
        end
        if (instr_valid && !prev_valid) begin
          chk("capture_expected", 64'(instr_q.size() != 0), 64'd1);
          if (instr_q.size() != 0) begin
            e = instr_q.pop_front();
            held_instr = e.instr;
            chk("capture_instr", 64'(instruction), 64'(e.instr));
            chk("capture_pc", pc, e.pc);
            chk("capture_count", 64'(retired_count), 64'(e.cnt));
          end
        end else if (instr_valid) begin
          chk("instr_stable", 64'(instruction), 64'(held_instr));
        end
        prev_req = imem_req;
        prev_valid = instr_valid;
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    summary();
    $finish;
  end

  task automatic randomize_ctrl();
    br = 1'($urandom_range(0, 1));
    ub = 1'($urandom_range(0, 1));
    zf = 1'($urandom_range(0, 1));
    bus_imm = {$urandom, $urandom};
  endtask

  // Reset for one edge, check reset values, then confirm the single idle cycle
  task automatic do_reset(input bit late_ready);
    rst = 1'b1;
    retire = 1'b0;
    imem_ready = 1'b0;
    addr_q.delete();
    instr_q.delete();
    @(negedge clk);
    chk("rst_pc", pc, RST_PC);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instruction), 64'd0);
    chk("rst_count", 64'(retired_count), 64'd0);
    chk("rst_count_sat", 64'(cnt2), 64'd0);
    rst = 1'b0;
    pc_m = RST_PC;
    cnt_m = 0;
    addr_q.push_back('{pc: RST_PC, instr: 32'd0, cnt: 0});
    if (late_ready) begin
      imem_ready = 1'b1;
      imem_rdata = $urandom;
    end
    @(negedge clk);
    imem_ready = 1'b0;
    chk("idle_then_req", 64'(imem_req), 64'd1);
    chk("idle_no_capture_valid", 64'(instr_valid), 64'd0);
    chk("idle_no_capture_instr", 64'(instruction), 64'd0);
  endtask

  // One instruction: optional stall, capture, optional hold, then retire with branch controls
  task automatic xact(input int stall, input int hold, input logic [31:0] instr,
                      input logic b, input logic u, input logic z, input logic [63:0] imm,
                      input bit stray, input bit abort);
    int n;
    n = 0;
    while (!imem_req) begin
      if (n >= 20) begin
        errors++;
        checks++;
        $display("FAIL fetch_timeout actual=no_req required=req");
        summary();
        $finish;
        return;
      end
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < stall; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      retire = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      randomize_ctrl();
      @(negedge clk);
    end
    imem_ready = 1'b1;
    imem_rdata = instr;
    retire = 1'b0;
    instr_q.push_back('{pc: pc_m, instr: instr, cnt: cnt_m});
    @(negedge clk);
    imem_ready = 1'b0;
    if (abort) begin
      @(negedge clk);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      randomize_ctrl();
      @(negedge clk);
    end
    imem_ready = 1'b0;
    retire = 1'b1;
    br = b;
    ub = u;
    zf = z;
    bus_imm = imm;
    if (u || (b && z)) pc_m = pc_m + imm;
    else pc_m = pc_m + 64'd4;
    cnt_m++;
    addr_q.push_back('{pc: pc_m, instr: 32'd0, cnt: cnt_m});
    @(negedge clk);
    retire = 1'b0;
    randomize_ctrl();
  endtask

  task automatic jump_to(input logic [63:0] target);
    xact(0, 0, $urandom, 1'b0, 1'b1, 1'b0, target - pc_m, 1'b0, 1'b0);
  endtask

  initial begin
    int k;
    logic [63:0] imm;
    do_reset(1'b0);
    xact(0, 0, 32'h8B020020, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    xact(0, 0, $urandom, 1'b0, 1'b0, 1'b1, 64'h40, 1'b0, 1'b0);
    xact(0, 0, $urandom, 1'b1, 1'b0, 1'b0, 64'h80, 1'b0, 1'b0);
    chk("three_retires_count", 64'(cnt_m), 64'd3);
    jump_to(64'h200);
    xact(0, 1, $urandom, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0);
    jump_to(64'h200);
    xact(0, 1, $urandom, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0);
    jump_to(64'h1000);
    xact(0, 0, $urandom, 1'b0, 1'b1, 1'b0, 64'h40, 1'b0, 1'b0);
    jump_to(64'hFFFF_FFFF_FFFF_FFFC);
    xact(0, 0, $urandom, 1'b0, 1'b0, 1'b1, 64'h100, 1'b0, 1'b0);
    xact(5, 3, $urandom, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    // Request is pending here: reset mid-fetch with a late ready
    do_reset(1'b1);
    xact(2, 0, $urandom, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    xact(0, 0, $urandom, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    // Now in HOLD: reset discards the held instruction
    do_reset(1'b0);
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        imm = {$urandom, $urandom};
      end else begin
        k = int'($urandom_range(0, 64)) - 32;
        imm = 64'(k * 4);
      end
      xact(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           imm, 1'b1, 1'b0);
    end
    repeat (2) @(negedge clk);
    chk("final_count", 64'(retired_count), 64'(cnt_m));
    chk("final_count_sat", 64'(cnt2), 64'd3);
    chk("addr_q_drained", 64'(addr_q.size()), 64'd0);
    chk("instr_q_drained", 64'(instr_q.size()), 64'd0);
    summary();
    $finish;
  end

endmodule
